// File: rtl/shake256_arbiter.sv
// shake256_arbiter
// Round-robin arbiter that lends a single shake256_top core to one of NREQ
// hash clients for one complete hash: start pulse, absorb words, then exactly
// the requested number of squeeze words, then a one-cycle done pulse.
// No data is buffered; the winner's absorb stream and the core's squeeze
// stream are steered combinationally by the registered grant.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i[NREQ]            per-client request for one hash transaction
//   out_words_i            per-client squeeze word count, slice k = [k*OWW+:OWW]
//   din_i                  per-client absorb data, slice k = [k*64+:64]
//   din_valid_i            per-client absorb valid
//   last_din_i             per-client last absorb word flag
//   last_din_byte_i        per-client valid bytes of last word, slice k = [k*4+:4]
//   dout_ready_i           per-client squeeze ready
//   gnt_o                  one-hot registered grant
//   din_ready_o            absorb ready, granted client only
//   dout_o                 squeeze data, broadcast
//   dout_valid_o           squeeze valid, granted client only
//   done_o                 one-cycle transaction-complete pulse
//   shake_*_o / shake_*_i  connection to shake256_top

module shake256_arbiter #(
    parameter int NREQ = 4,
    parameter int OWW  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*OWW-1:0] out_words_i,
    input  logic [NREQ*64-1:0]  din_i,
    input  logic [NREQ-1:0]     din_valid_i,
    input  logic [NREQ-1:0]     last_din_i,
    input  logic [NREQ*4-1:0]   last_din_byte_i,
    input  logic [NREQ-1:0]     dout_ready_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     din_ready_o,
    output logic [63:0]         dout_o,
    output logic [NREQ-1:0]     dout_valid_o,
    output logic [NREQ-1:0]     done_o,
    output logic                shake_start_o,
    output logic [63:0]         shake_din_o,
    output logic                shake_din_valid_o,
    output logic                shake_last_din_o,
    output logic [3:0]          shake_last_din_byte_o,
    output logic                shake_dout_ready_o,
    input  logic                shake_din_ready_i,
    input  logic [63:0]         shake_dout_i,
    input  logic                shake_dout_valid_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   rr_ptr;
    logic [OWW-1:0]  cnt;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [OWW-1:0]  win_words;

    logic [63:0]     sel_din;
    logic            sel_din_valid;
    logic            sel_last;
    logic [3:0]      sel_last_byte;
    logic            sel_dout_ready;

    logic            din_hs;
    logic            dout_hs;

    // Round-robin pick: first scan the requesters above the pointer, then wrap
    // to those at or below it, so the last served client has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_words = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_i[k] && (k > int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_oh[k] = 1'b1;
                win_words = out_words_i[k*OWW +: OWW];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_i[k] && (k <= int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_oh[k] = 1'b1;
                win_words = out_words_i[k*OWW +: OWW];
            end
        end
    end

    // AND-OR steering of the granted client's slices; grant is one-hot.
    always_comb begin
        sel_din        = '0;
        sel_din_valid  = 1'b0;
        sel_last       = 1'b0;
        sel_last_byte  = '0;
        sel_dout_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                sel_din        = din_i[k*64 +: 64];
                sel_din_valid  = din_valid_i[k];
                sel_last       = last_din_i[k];
                sel_last_byte  = last_din_byte_i[k*4 +: 4];
                sel_dout_ready = dout_ready_i[k];
            end
        end
    end

    assign din_hs  = (state == S_ABSORB) && sel_din_valid && shake_din_ready_i;
    assign dout_hs = (state == S_SQUEEZE) && shake_dout_valid_i && sel_dout_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An absorb-only request (zero squeeze words) skips S_SQUEEZE entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (win_found) state_nxt = S_START;
            S_START:   state_nxt = S_ABSORB;
            S_ABSORB:  if (din_hs && sel_last) state_nxt = (cnt == '0) ? S_DONE : S_SQUEEZE;
            S_SQUEEZE: if (dout_hs && (cnt == OWW'(1))) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Grant, winner index and squeeze counter are captured at arbitration;
    // the pointer moves to the served client only once its hash completes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_q   <= '0;
            gnt_idx <= '0;
            rr_ptr  <= IW'(NREQ - 1);
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_q   <= win_oh;
                        gnt_idx <= win_idx;
                        cnt     <= win_words;
                    end
                end
                S_SQUEEZE: begin
                    if (dout_hs) cnt <= cnt - OWW'(1);
                end
                S_DONE: begin
                    rr_ptr <= gnt_idx;
                    gnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Everything is gated by state so nothing leaks to the core or to
    // non-granted clients outside the phase it belongs to.
    always_comb begin
        shake_start_o         = 1'b0;
        shake_din_o           = '0;
        shake_din_valid_o     = 1'b0;
        shake_last_din_o      = 1'b0;
        shake_last_din_byte_o = '0;
        shake_dout_ready_o    = 1'b0;
        din_ready_o           = '0;
        dout_o                = '0;
        dout_valid_o          = '0;
        done_o                = '0;
        case (state)
            S_START: shake_start_o = 1'b1;
            S_ABSORB: begin
                shake_din_o           = sel_din;
                shake_din_valid_o     = sel_din_valid;
                shake_last_din_o      = sel_last;
                shake_last_din_byte_o = sel_last_byte;
                din_ready_o           = gnt_q & {NREQ{shake_din_ready_i}};
            end
            S_SQUEEZE: begin
                dout_o             = shake_dout_i;
                dout_valid_o       = gnt_q & {NREQ{shake_dout_valid_i}};
                shake_dout_ready_o = sel_dout_ready;
            end
            S_DONE: done_o = gnt_q;
            default: ;
        endcase
    end

    assign gnt_o = gnt_q;

endmodule
